// File: rtl/hakutpu_alu_pkg.sv
// Shared constants and types for the FP16 ALU array and its downstream stages.
// Optional writeback error flags are enabled with the ALU_WB_ERR_EN macro.
package hakutpu_alu_pkg;

    localparam int FP16_W      = 16;
    localparam int ALU_LANES   = 16;
    localparam int ALU_LATENCY = 5;
    // Every op in the ALU pipe plus the one being issued needs a reserved slot.
    localparam int MIN_WB_DEPTH = ALU_LATENCY + 1;

    typedef logic [ALU_LANES-1:0][FP16_W-1:0] fp16_vec_t;

    localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;
    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

    function automatic logic is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/hakutpu_sync_fifo.sv
// Single-clock FIFO with registered count; push into a full FIFO is honoured
// only when a pop frees the slot in the same cycle.
module hakutpu_sync_fifo
    import hakutpu_alu_pkg::*;
#(
    parameter int W     = FP16_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             data_i,
    output logic [W-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/alu_result_writeback.sv
// Pairs ALU result vectors with in-order destination addresses and issues
// credits to the issue stage. ALU_WB_ERR_EN adds sticky err_overflow/err_orphan.
module alu_result_writeback
    import hakutpu_alu_pkg::*;
#(
    parameter int LANES  = ALU_LANES,
    parameter int DATA_W = FP16_W,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_addr,
    output logic                      issue_ready,
    input  logic                      res_valid,
    input  logic [LANES*DATA_W-1:0]   res_data,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [LANES*DATA_W-1:0]   wr_data,
    output logic                      idle
`ifdef ALU_WB_ERR_EN
    ,
    output logic                      err_overflow,
    output logic                      err_orphan
`endif
);
    localparam int VEC_W = LANES * DATA_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    if (!is_pow2(DEPTH) || DEPTH < MIN_WB_DEPTH) begin : g_bad_depth
        $error("alu_result_writeback: DEPTH must be a power of two and >= ALU latency + 1");
    end

    logic [CNT_W-1:0] credits_q, credits_d;
    logic             issue_acc, wr_hs;
    logic             addr_full, addr_empty, res_full, res_empty;
    logic [CNT_W-1:0] addr_count, res_count;
    logic             unused_status;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // issue_ready comes only from the credit register; wr_valid only from
    // FIFO state, so once raised it and its payload hold until wr_ready.
    assign issue_ready = (credits_q != '0);
    assign issue_acc   = issue_valid && issue_ready;
    assign wr_valid    = !addr_empty && !res_empty;
    assign wr_hs       = wr_valid && wr_ready;
    assign idle        = (credits_q == CNT_W'(DEPTH));

    always_comb begin
        credits_d = credits_q;
        unique case ({issue_acc, wr_hs})
            2'b10:   credits_d = credits_q - CNT_W'(1);
            2'b01:   credits_d = credits_q + CNT_W'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) credits_q <= CNT_W'(DEPTH);
        else     credits_q <= credits_d;
    end

    hakutpu_sync_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_addr_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (issue_acc),
        .pop_i   (wr_hs),
        .data_i  (issue_addr),
        .data_o  (wr_addr),
        .full_o  (addr_full),
        .empty_o (addr_empty),
        .count_o (addr_count)
    );

    // Results cannot be stalled upstream; a push into a full FIFO is dropped.
    hakutpu_sync_fifo #(.W(VEC_W), .DEPTH(DEPTH)) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (res_valid),
        .pop_i   (wr_hs),
        .data_i  (res_data),
        .data_o  (wr_data),
        .full_o  (res_full),
        .empty_o (res_empty),
        .count_o (res_count)
    );

`ifdef ALU_WB_ERR_EN
    logic err_overflow_q, err_orphan_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overflow_q <= 1'b0;
            err_orphan_q   <= 1'b0;
        end else begin
            if (res_valid && res_full && !wr_hs) err_overflow_q <= 1'b1;
            if (res_valid && (res_count >= addr_count)) err_orphan_q <= 1'b1;
        end
    end

    assign err_overflow = err_overflow_q;
    assign err_orphan   = err_orphan_q;
`endif

    assign unused_status = ^{addr_full, res_full, addr_count, res_count};

endmodule

// File: tb/tb_alu_result_writeback.sv
// Self-checking bench for alu_result_writeback; a negedge monitor pairs every
// write handshake with the scoreboard queue filled at issue time.
module tb_alu_result_writeback;
    import hakutpu_alu_pkg::*;

    localparam int ADDR_W = 12;
    localparam int LANES  = ALU_LANES;
    localparam int DATA_W = FP16_W;
    localparam int VEC_W  = LANES * DATA_W;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_ready;
    logic              res_valid;
    logic [VEC_W-1:0]  res_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [VEC_W-1:0]  wr_data;
    logic              idle;
`ifdef ALU_WB_ERR_EN
    logic              err_overflow;
    logic              err_orphan;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [ADDR_W+VEC_W-1:0] exp_q[$];
    logic [VEC_W-1:0]        res_pend[$];
    logic [ADDR_W+VEC_W-1:0] exp_item;
    logic                    stall_prev = 1'b0;
    logic [ADDR_W-1:0]       held_addr;
    logic [VEC_W-1:0]        held_data;

    alu_result_writeback #(
        .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .idle        (idle)
`ifdef ALU_WB_ERR_EN
        ,
        .err_overflow(err_overflow),
        .err_orphan  (err_orphan)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_cmp++;
                if (wr_valid !== 1'b1 || wr_addr !== held_addr || wr_data !== held_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%b addr=%h, required valid=1 addr=%h with data unchanged",
                             wr_valid, wr_addr, held_addr);
                end
            end
            if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got addr=%h, required no write", wr_addr);
                end else begin
                    exp_item = exp_q.pop_front();
                    if ({wr_addr, wr_data} !== exp_item) begin
                        n_fail++;
                        $display("FAIL write_pair: got addr=%h data=%h, required addr=%h data=%h",
                                 wr_addr, wr_data, exp_item[ADDR_W+VEC_W-1:VEC_W], exp_item[VEC_W-1:0]);
                    end
                end
            end
            stall_prev = (wr_valid === 1'b1 && wr_ready === 1'b0);
            held_addr  = wr_addr;
            held_data  = wr_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 65535));
        return v;
    endfunction

    function automatic logic [VEC_W-1:0] fill_vec(input logic [DATA_W-1:0] lane);
        logic [VEC_W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = lane;
        return v;
    endfunction

    task automatic push_expect(input logic [ADDR_W-1:0] addr, input logic [VEC_W-1:0] data);
        exp_q.push_back({addr, data});
        res_pend.push_back(data);
    endtask

    task automatic issue_op(input logic [ADDR_W-1:0] addr, input logic [VEC_W-1:0] data);
        issue_valid = 1'b1;
        issue_addr  = addr;
        push_expect(addr, data);
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic send_res();
        res_valid = 1'b1;
        res_data  = (res_pend.size() != 0) ? res_pend.pop_front() : rand_vec();
        tick();
        res_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while (idle !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        n_cmp++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_drain_timeout: got idle=%b after %0d cycles, required 1", name, idle, limit);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp += 3;
        if (wr_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_wr_valid: got %b, required 0", wr_valid); end
        if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %b, required 1", issue_ready); end
        if (idle !== 1'b1)        begin n_fail++; $display("FAIL reset_idle: got %b, required 1", idle); end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (idle !== 1'b1 || wr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_state: got idle=%b wr_valid=%b, required 1/0", idle, wr_valid);
        end
    endtask

    task automatic test_single_op();
        logic [VEC_W-1:0] ones;
        ones = fill_vec(FP16_ONE);
        wr_ready = 1'b1;
        issue_op(12'h010, ones);
        repeat (4) tick();
        send_res();
        n_cmp += 3;
        if (wr_valid !== 1'b1)  begin n_fail++; $display("FAIL single_wr_valid: got %b, required 1", wr_valid); end
        if (wr_addr !== 12'h010) begin n_fail++; $display("FAIL single_wr_addr: got %h, required 010", wr_addr); end
        if (wr_data !== ones)   begin n_fail++; $display("FAIL single_wr_data: got %h, required %h", wr_data, ones); end
        tick();
        n_cmp += 2;
        if (idle !== 1'b1 || issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_after: got idle=%b issue_ready=%b, required 1/1", idle, issue_ready);
        end
        if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_repeat: got wr_valid=%b, required 0", wr_valid); end
    endtask

    task automatic test_credit_exhaustion();
        logic [ADDR_W-1:0] a;
        wr_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            a = ADDR_W'($urandom_range(0, 4095));
            issue_valid = 1'b1;
            issue_addr  = a;
            push_expect(a, rand_vec());
            tick();
            n_cmp++;
            if (issue_ready !== (k < DEPTH - 1)) begin
                n_fail++;
                $display("FAIL credit_ready_after_%0d: got %b, required %b", k + 1, issue_ready, k < DEPTH - 1);
            end
        end
        a = ADDR_W'($urandom_range(0, 4095));
        issue_addr = a;
        push_expect(a, rand_vec());
        for (int k = 0; k < DEPTH; k++) begin
            res_valid = 1'b1;
            res_data  = res_pend.pop_front();
            tick();
        end
        res_valid = 1'b0;
        n_cmp++;
        if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL credit_ninth_blocked: got %b, required 0", issue_ready); end
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        n_cmp++;
        if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL credit_returned: got %b, required 1", issue_ready); end
        tick();
        issue_valid = 1'b0;
        n_cmp++;
        if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL credit_ninth_taken: got %b, required 0", issue_ready); end
        send_res();
        wr_ready = 1'b1;
        wait_idle(40, "credit");
    endtask

    task automatic test_backpressure();
        wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) issue_op(ADDR_W'($urandom_range(0, 4095)), rand_vec());
        repeat (4) tick();
        for (int k = 0; k < 3; k++) send_res();
        for (int i = 0; i < 16; i++) begin
            wr_ready = i[0];
            tick();
        end
        wr_ready = 1'b1;
        wait_idle(20, "backpressure");
        n_cmp++;
        if (exp_q.size() != 0 || issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_drain: got pending=%0d issue_ready=%b, required 0/1", exp_q.size(), issue_ready);
        end
    endtask

    task automatic test_simultaneous();
        logic [ADDR_W-1:0] a;
        wr_ready = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) issue_op(ADDR_W'($urandom_range(0, 4095)), rand_vec());
        for (int k = 0; k < DEPTH - 1; k++) send_res();
        n_cmp++;
        if (issue_ready !== 1'b1 || wr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_setup: got issue_ready=%b wr_valid=%b, required 1/1", issue_ready, wr_valid);
        end
        a = ADDR_W'($urandom_range(0, 4095));
        issue_valid = 1'b1;
        issue_addr  = a;
        push_expect(a, rand_vec());
        wr_ready = 1'b1;
        tick();
        issue_valid = 1'b0;
        wr_ready    = 1'b0;
        n_cmp++;
        if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL simul_credit_kept: got %b, required 1", issue_ready); end
        issue_op(ADDR_W'($urandom_range(0, 4095)), rand_vec());
        n_cmp++;
        if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL simul_credit_exact: got %b, required 0", issue_ready); end
        send_res();
        send_res();
        wr_ready = 1'b1;
        wait_idle(30, "simul");
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] a;
        wr_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            issue_valid = (c < DEPTH);
            if (c < DEPTH) begin
                a = ADDR_W'($urandom_range(0, 4095));
                issue_addr = a;
                push_expect(a, rand_vec());
            end
            res_valid = (c >= 5 && c < 5 + DEPTH);
            if (c >= 5 && c < 5 + DEPTH) res_data = res_pend.pop_front();
            tick();
            if (c >= 5 && c < 5 + DEPTH) begin
                n_cmp++;
                if (wr_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_throughput_c%0d: got wr_valid=%b, required 1", c, wr_valid);
                end
            end
        end
        issue_valid = 1'b0;
        res_valid   = 1'b0;
        wait_idle(20, "b2b");
    endtask

    task automatic test_reset_mid_burst();
        wr_ready = 1'b0;
        for (int k = 0; k < 4; k++) issue_op(ADDR_W'($urandom_range(0, 4095)), rand_vec());
        for (int k = 0; k < 4; k++) send_res();
        n_cmp++;
        if (wr_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_setup: got wr_valid=%b, required 1", wr_valid); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (wr_valid !== 1'b0 || issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_async: got wr_valid=%b issue_ready=%b, required 0/1", wr_valid, issue_ready);
        end
        exp_q.delete();
        res_pend.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (issue_ready !== 1'b1 || idle !== 1'b1 || wr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: got issue_ready=%b idle=%b wr_valid=%b, required 1/1/0",
                     issue_ready, idle, wr_valid);
        end
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale_%0d: got wr_valid=%b, required 0", i, wr_valid); end
        end
        issue_op(12'hABC, fill_vec(FP16_ZERO));
        repeat (4) tick();
        send_res();
        wait_idle(10, "rstmid");
    endtask

`ifdef ALU_WB_ERR_EN
    task automatic test_errors();
        rst = 1'b1;
        exp_q.delete();
        res_pend.delete();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (err_overflow !== 1'b0 || err_orphan !== 1'b0) begin
            n_fail++;
            $display("FAIL err_reset: got ovf=%b orph=%b, required 0/0", err_overflow, err_orphan);
        end
        wr_ready = 1'b1;
        send_res();
        repeat (3) tick();
        n_cmp++;
        if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL err_orphan_sticky: got %b, required 1", err_orphan); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (err_orphan !== 1'b0) begin n_fail++; $display("FAIL err_orphan_cleared: got %b, required 0", err_orphan); end
        wr_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) issue_op(ADDR_W'($urandom_range(0, 4095)), rand_vec());
        for (int k = 0; k < DEPTH + 1; k++) send_res();
        n_cmp++;
        if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL err_overflow_set: got %b, required 1", err_overflow); end
        wr_ready = 1'b1;
        wait_idle(30, "err");
        tick();
        n_cmp++;
        if (wr_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL err_only_eight: got wr_valid=%b pending=%0d, required 0/0", wr_valid, exp_q.size());
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        rst         = 1'b1;
        issue_valid = 1'b0;
        issue_addr  = '0;
        res_valid   = 1'b0;
        res_data    = '0;
        wr_ready    = 1'b0;
        test_reset();
        test_single_op();
        test_credit_exhaustion();
        test_backpressure();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_burst();
`ifdef ALU_WB_ERR_EN
        test_errors();
`endif
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: got %0d pending writes, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
